uart_rx_param: RTL and testbench
================================

Name: uart_rx_param

Overview:
Parametrised UART receiver, the successor to the fixed 8N1 receiver. It oversamples the serial line with a baud tick and supports configurable data width, oversampling ratio, parity and stop-bit count. It reports framing and parity errors and rejects false starts. It sits between the pad-side rx line and the byte consumer (FIFO/ALU interface) in the UART top.

Parameters:
DATA_BITS, 8, data bits per frame, legal 5..9, sent LSB first
OVERSAMPLE, 16, baud_tick pulses per bit period, even, legal 8..32
PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, number of stop bits, legal 1 or 2

Ports:
clk  in  1  system clock, all logic on posedge
rst_count  in  1  asynchronous active-low reset
baud_tick  in  1  one-clk-wide enable pulse at OVERSAMPLE x baud rate, synchronous to clk
rx  in  1  serial line, idle high
d_out  out  DATA_BITS  received word, held until the next completed frame
rx_done  out  1  one-clk pulse: frame complete, d_out and error flags valid
frame_err  out  1  stop bit sampled low in the last frame; valid with rx_done
parity_err  out  1  parity mismatch in the last frame; valid with rx_done, 0 when PARITY_MODE = 0

Behaviour:
- Reset rst_count, asynchronous, active-low; clock clk.
- Reset values: d_out = 0, rx_done = 0, frame_err = 0, parity_err = 0, state = IDLE, tick counter = 0, bit counter = 0, shift register = 0.
- All state and counter changes occur only on clk edges where baud_tick = 1, except the rx_done clear (see below).
- Tick counter width: $clog2(OVERSAMPLE). Bit counter width: $clog2(DATA_BITS+1).
- Sampling point: tick count OVERSAMPLE/2-1 for the start bit. Every subsequent bit is sampled after OVERSAMPLE further ticks, i.e. mid-bit.
- States:
  - IDLE: on a tick with rx = 0, clear the tick counter and go to START.
  - START: count ticks. At OVERSAMPLE/2-1, if rx = 1 this is a false start: return to IDLE with no rx_done. Otherwise clear the tick counter and go to DATA.
  - DATA: at tick OVERSAMPLE-1, shift rx into the MSB of the shift register (right shift) and increment the bit counter. After DATA_BITS samples, go to PARITY if PARITY_MODE != 0, else to STOP.
  - PARITY: sample rx at tick OVERSAMPLE-1.
    - Even mode: error if XOR(data, parity bit) != 0.
    - Odd mode: error if XOR(data, parity bit) != 1.
    - Then go to STOP.
  - STOP: sample rx at tick OVERSAMPLE-1 for each of STOP_BITS bits. Any low sample sets the pending frame error. After the last stop sample:
    - d_out <= shift register.
    - frame_err and parity_err <= pending values.
    - rx_done = 1 for exactly one clk.
    - Go to IDLE if the frame is OK, else to BREAK.
  - BREAK: wait for a tick with rx = 1, then go to IDLE. This prevents a held-low line from generating repeated frames.
- rx_done clears on the next clk regardless of baud_tick.
- Latency: rx_done asserts on the clk edge of the final stop-bit sample tick.
- d_out and the error flags are stable from rx_done until the next rx_done.
- Reset mid-frame: immediate return to the reset values; the partial frame is discarded.
- The bit counter and pending error flags clear on entry to START.

Optional Feature:
UART_RX_MAJORITY_EN.
- Defined: every sample (start, data, parity, stop) is the 2-of-3 majority of rx at ticks S-1, S and S+1, where S is the nominal sample tick. The decision is taken at S+1, shifting all sample points one tick later. This rejects single-tick glitches.
- Undefined: a single sample at S, as described above.

Test Plan:
- Defaults, send 0xA5 (8N1, 16 ticks/bit, LSB first) -> rx_done pulse 1 clk, d_out = 8'hA5, frame_err = 0, parity_err = 0.
- Defaults, rx low for 5 ticks then high (false start) -> no rx_done, state back to IDLE. A following 0x3C frame is received correctly.
- PARITY_MODE = 1, send 0x07 with parity bit 0 (wrong) -> d_out = 8'h07, parity_err = 1. Resend with parity bit 1 -> parity_err = 0.
- STOP_BITS = 2, send 0x55 with the second stop bit low -> frame_err = 1, d_out = 8'h55. Hold rx low for 40 bit times -> no further rx_done until rx returns high.
- DATA_BITS = 5, OVERSAMPLE = 8, PARITY_MODE = 2, send 5'h13 -> d_out = 5'h13, parity_err = 0. Assert rst_count during bit 2 of the next frame -> all outputs 0, no rx_done.
- UART_RX_MAJORITY_EN defined, one-tick glitch to 0 at the sample point of a '1' data bit in 0xFF -> d_out = 8'hFF. Without the macro -> d_out = 8'hFE (glitch on bit 0).

Source files
------------

// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver: configurable data width, parity and stop bits.
// Optional macro UART_RX_MAJORITY_EN: each sample becomes a 2-of-3 vote taken one tick later.
module uart_rx_param #(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                 clk,
    input  logic                 rst_count,
    input  logic                 baud_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] d_out,
    output logic                 rx_done,
    output logic                 frame_err,
    output logic                 parity_err
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;
    localparam logic [2:0] BREAK  = 3'd5;

    localparam logic [TW-1:0] BIT_TICK = TW'(OVERSAMPLE - 1);

    logic sample;

`ifdef UART_RX_MAJORITY_EN
    localparam logic [TW-1:0] START_TICK = TW'(OVERSAMPLE / 2);

    // rx at the two previous ticks; the current rx is the third vote
    logic [1:0] hist_q;

    always_ff @(posedge clk or negedge rst_count) begin
        if (!rst_count) begin
            hist_q <= 2'b11;
        end else if (baud_tick) begin
            hist_q <= {hist_q[0], rx};
        end
    end

    assign sample = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx) | (hist_q[0] & rx);
`else
    localparam logic [TW-1:0] START_TICK = TW'(OVERSAMPLE / 2 - 1);

    assign sample = rx;
`endif

    logic [2:0]           state_q, state_d;
    logic [TW-1:0]        tickCnt_q, tickCnt_d;
    logic [BW-1:0]        bitCnt_q, bitCnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 frameErrPend_q, frameErrPend_d;
    logic                 parErrPend_q, parErrPend_d;
    logic [DATA_BITS-1:0] dOut_q, dOut_d;
    logic                 rxDone_q, rxDone_d;
    logic                 frameErr_q, frameErr_d;
    logic                 parErr_q, parErr_d;

    always_comb begin
        state_d        = state_q;
        tickCnt_d      = tickCnt_q;
        bitCnt_d       = bitCnt_q;
        shift_d        = shift_q;
        frameErrPend_d = frameErrPend_q;
        parErrPend_d   = parErrPend_q;
        dOut_d         = dOut_q;
        rxDone_d       = 1'b0;
        frameErr_d     = frameErr_q;
        parErr_d       = parErr_q;

        if (baud_tick) begin
            case (state_q)
                IDLE: begin
                    if (!rx) begin
                        tickCnt_d      = '0;
                        bitCnt_d       = '0;
                        frameErrPend_d = 1'b0;
                        parErrPend_d   = 1'b0;
                        state_d        = START;
                    end
                end
                START: begin
                    if (tickCnt_q == START_TICK) begin
                        tickCnt_d = '0;
                        state_d   = sample ? IDLE : DATA;
                    end else begin
                        tickCnt_d = tickCnt_q + TW'(1);
                    end
                end
                DATA: begin
                    if (tickCnt_q == BIT_TICK) begin
                        tickCnt_d = '0;
                        shift_d   = {sample, shift_q[DATA_BITS-1:1]};
                        bitCnt_d  = bitCnt_q + BW'(1);
                        if (bitCnt_q == BW'(DATA_BITS - 1)) begin
                            bitCnt_d = '0;
                            state_d  = (PARITY_MODE != 0) ? PARITY : STOP;
                        end
                    end else begin
                        tickCnt_d = tickCnt_q + TW'(1);
                    end
                end
                PARITY: begin
                    if (tickCnt_q == BIT_TICK) begin
                        tickCnt_d    = '0;
                        parErrPend_d = (PARITY_MODE == 1) ? (^shift_q ^ sample)
                                                          : ~(^shift_q ^ sample);
                        state_d      = STOP;
                    end else begin
                        tickCnt_d = tickCnt_q + TW'(1);
                    end
                end
                STOP: begin
                    if (tickCnt_q == BIT_TICK) begin
                        tickCnt_d = '0;
                        if (!sample) begin
                            frameErrPend_d = 1'b1;
                        end
                        if (bitCnt_q == BW'(STOP_BITS - 1)) begin
                            bitCnt_d   = '0;
                            dOut_d     = shift_q;
                            frameErr_d = frameErrPend_q | ~sample;
                            parErr_d   = parErrPend_q;
                            rxDone_d   = 1'b1;
                            state_d    = (frameErrPend_q | ~sample | parErrPend_q) ? BREAK : IDLE;
                        end else begin
                            bitCnt_d = bitCnt_q + BW'(1);
                        end
                    end else begin
                        tickCnt_d = tickCnt_q + TW'(1);
                    end
                end
                // a line held low must return high before a new start is accepted
                BREAK: begin
                    if (rx) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_count) begin
        if (!rst_count) begin
            state_q        <= IDLE;
            tickCnt_q      <= '0;
            bitCnt_q       <= '0;
            shift_q        <= '0;
            frameErrPend_q <= 1'b0;
            parErrPend_q   <= 1'b0;
            dOut_q         <= '0;
            rxDone_q       <= 1'b0;
            frameErr_q     <= 1'b0;
            parErr_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            tickCnt_q      <= tickCnt_d;
            bitCnt_q       <= bitCnt_d;
            shift_q        <= shift_d;
            frameErrPend_q <= frameErrPend_d;
            parErrPend_q   <= parErrPend_d;
            dOut_q         <= dOut_d;
            rxDone_q       <= rxDone_d;
            frameErr_q     <= frameErr_d;
            parErr_q       <= parErr_d;
        end
    end

    assign d_out      = dOut_q;
    assign rx_done    = rxDone_q;
    assign frame_err  = frameErr_q;
    assign parity_err = parErr_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Testbench for uart_rx_param: four differently configured receivers fed directed frames,
// with a scoreboard of expected words checked whenever a receiver pulses rx_done.
module tb_uart_rx_param;

    typedef struct packed {
        logic [8:0] data;
        logic       fe;
        logic       pe;
    } expT;

    logic       clk;
    logic       rst_count;
    logic       baud_tick;
    logic       rx0, rx1, rx2, rx3;
    logic [7:0] dout0, dout1, dout2;
    logic [4:0] dout3;
    logic       done0, done1, done2, done3;
    logic       fe0, fe1, fe2, fe3;
    logic       pe0, pe1, pe2, pe3;

    int  nAsserts = 0;
    int  nFails   = 0;
    int  doneCnt0 = 0, doneCnt1 = 0, doneCnt2 = 0, doneCnt3 = 0;
    logic prev0 = 1'b0, prev1 = 1'b0, prev2 = 1'b0, prev3 = 1'b0;
    expT expQ0[$], expQ1[$], expQ2[$], expQ3[$];

    uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_MODE(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .rst_count(rst_count), .baud_tick(baud_tick), .rx(rx0),
        .d_out(dout0), .rx_done(done0), .frame_err(fe0), .parity_err(pe0));

    uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_MODE(1), .STOP_BITS(1)) dut1 (
        .clk(clk), .rst_count(rst_count), .baud_tick(baud_tick), .rx(rx1),
        .d_out(dout1), .rx_done(done1), .frame_err(fe1), .parity_err(pe1));

    uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_MODE(0), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst_count(rst_count), .baud_tick(baud_tick), .rx(rx2),
        .d_out(dout2), .rx_done(done2), .frame_err(fe2), .parity_err(pe2));

    uart_rx_param #(.DATA_BITS(5), .OVERSAMPLE(8), .PARITY_MODE(2), .STOP_BITS(1)) dut3 (
        .clk(clk), .rst_count(rst_count), .baud_tick(baud_tick), .rx(rx3),
        .d_out(dout3), .rx_done(done3), .frame_err(fe3), .parity_err(pe3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pushExpect(input int dut, input logic [8:0] data, input logic fe, input logic pe);
        expT e;
        e.data = data;
        e.fe   = fe;
        e.pe   = pe;
        case (dut)
            0: expQ0.push_back(e);
            1: expQ1.push_back(e);
            2: expQ2.push_back(e);
            default: expQ3.push_back(e);
        endcase
    endtask

    function automatic int qSize(input int dut);
        case (dut)
            0: return expQ0.size();
            1: return expQ1.size();
            2: return expQ2.size();
            default: return expQ3.size();
        endcase
    endfunction

    task automatic checkDone(input int dut, input logic [8:0] dout, input logic fe, input logic pe);
        expT e;
        int  avail;
        avail = qSize(dut);
        checkOutput($sformatf("dut%0d rx_done with expectation queued", dut), (avail > 0) ? 1 : 0, 1);
        if (avail > 0) begin
            case (dut)
                0: e = expQ0.pop_front();
                1: e = expQ1.pop_front();
                2: e = expQ2.pop_front();
                default: e = expQ3.pop_front();
            endcase
            checkOutput($sformatf("dut%0d d_out", dut), 32'(dout), 32'(e.data));
            checkOutput($sformatf("dut%0d frame_err", dut), 32'(fe), 32'(e.fe));
            checkOutput($sformatf("dut%0d parity_err", dut), 32'(pe), 32'(e.pe));
        end
    endtask

    // Scoreboard side: pop and compare on every rx_done, and insist the pulse is one clk wide
    always @(negedge clk) begin
        if (prev0) checkOutput("dut0 rx_done one clk", 32'(done0), 0);
        if (prev1) checkOutput("dut1 rx_done one clk", 32'(done1), 0);
        if (prev2) checkOutput("dut2 rx_done one clk", 32'(done2), 0);
        if (prev3) checkOutput("dut3 rx_done one clk", 32'(done3), 0);
        if (done0) begin doneCnt0++; checkDone(0, 9'(dout0), fe0, pe0); end
        if (done1) begin doneCnt1++; checkDone(1, 9'(dout1), fe1, pe1); end
        if (done2) begin doneCnt2++; checkDone(2, 9'(dout2), fe2, pe2); end
        if (done3) begin doneCnt3++; checkDone(3, 9'(dout3), fe3, pe3); end
        prev0 = done0;
        prev1 = done1;
        prev2 = done2;
        prev3 = done3;
    end

    // Called at a negedge: one baud tick, then three idle clocks
    task automatic doTick();
        baud_tick = 1'b1;
        @(negedge clk);
        baud_tick = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic setRx(input int dut, input logic v);
        case (dut)
            0: rx0 = v;
            1: rx1 = v;
            2: rx2 = v;
            default: rx3 = v;
        endcase
    endtask

    task automatic idleSlots(input int dut, input logic v, input int n);
        for (int s = 0; s < n; s++) begin
            setRx(dut, v);
            doTick();
        end
    endtask

    task automatic driveBit(input int dut, input logic v, input int os, input int glitchSlot);
        for (int s = 0; s < os; s++) begin
            setRx(dut, (s == glitchSlot) ? ~v : v);
            doTick();
        end
    endtask

    task automatic applyStimulus(input int dut, input logic [8:0] data, input int nBits, input int os,
                                 input bit hasPar, input bit parBit, input int nStop,
                                 input bit lastStopVal, input int glitchBit);
        driveBit(dut, 1'b0, os, -1);
        for (int i = 0; i < nBits; i++) begin
            driveBit(dut, data[i], os, (i == glitchBit) ? os / 2 : -1);
        end
        if (hasPar) begin
            driveBit(dut, parBit, os, -1);
        end
        for (int k = 0; k < nStop; k++) begin
            driveBit(dut, (k == nStop - 1) ? lastStopVal : 1'b1, os, -1);
        end
    endtask

    initial begin
        int         savedCnt;
        logic [8:0] glitchExp;
        logic [4:0] w3;

        rst_count = 1'b0;
        baud_tick = 1'b0;
        rx0 = 1'b1; rx1 = 1'b1; rx2 = 1'b1; rx3 = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("reset dut0 d_out", 32'(dout0), 0);
        checkOutput("reset dut0 rx_done", 32'(done0), 0);
        checkOutput("reset dut0 frame_err", 32'(fe0), 0);
        checkOutput("reset dut0 parity_err", 32'(pe0), 0);
        checkOutput("reset dut3 d_out", 32'(dout3), 0);
        rst_count = 1'b1;
        idleSlots(0, 1'b1, 4);

        $display("[TB] 8N1 frame 0xA5");
        pushExpect(0, 9'h0A5, 1'b0, 1'b0);
        applyStimulus(0, 9'h0A5, 8, 16, 1'b0, 1'b0, 1, 1'b1, -1);
        idleSlots(0, 1'b1, 32);
        checkOutput("dut0 A5 frame consumed", qSize(0), 0);
        checkOutput("dut0 done count after A5", doneCnt0, 1);

        $display("[TB] false start then 0x3C");
        idleSlots(0, 1'b0, 5);
        idleSlots(0, 1'b1, 40);
        checkOutput("dut0 no rx_done on false start", doneCnt0, 1);
        checkOutput("dut0 d_out held after false start", 32'(dout0), 32'h0A5);
        pushExpect(0, 9'h03C, 1'b0, 1'b0);
        applyStimulus(0, 9'h03C, 8, 16, 1'b0, 1'b0, 1, 1'b1, -1);
        idleSlots(0, 1'b1, 32);
        checkOutput("dut0 3C frame consumed", qSize(0), 0);

        $display("[TB] even parity 0x07, wrong then right parity bit");
        pushExpect(1, 9'h007, 1'b0, 1'b1);
        applyStimulus(1, 9'h007, 8, 16, 1'b1, 1'b0, 1, 1'b1, -1);
        idleSlots(1, 1'b1, 32);
        pushExpect(1, 9'h007, 1'b0, 1'b0);
        applyStimulus(1, 9'h007, 8, 16, 1'b1, 1'b1, 1, 1'b1, -1);
        idleSlots(1, 1'b1, 32);
        checkOutput("dut1 parity frames consumed", qSize(1), 0);
        checkOutput("dut1 done count", doneCnt1, 2);

        $display("[TB] two stop bits, second low, then held-low line");
        pushExpect(2, 9'h055, 1'b1, 1'b0);
        applyStimulus(2, 9'h055, 8, 16, 1'b0, 1'b0, 2, 1'b0, -1);
        idleSlots(2, 1'b0, 40 * 16);
        checkOutput("dut2 single rx_done during break", doneCnt2, 1);
        checkOutput("dut2 frame_err held", 32'(fe2), 1);
        idleSlots(2, 1'b1, 20);
        pushExpect(2, 9'h055, 1'b0, 1'b0);
        applyStimulus(2, 9'h055, 8, 16, 1'b0, 1'b0, 2, 1'b1, -1);
        idleSlots(2, 1'b1, 32);
        checkOutput("dut2 frames consumed", qSize(2), 0);

        $display("[TB] single-tick glitch on bit 0 of 0xFF");
`ifdef UART_RX_MAJORITY_EN
        glitchExp = 9'h0FF;
`else
        glitchExp = 9'h0FE;
`endif
        pushExpect(0, glitchExp, 1'b0, 1'b0);
        applyStimulus(0, 9'h0FF, 8, 16, 1'b0, 1'b0, 1, 1'b1, 0);
        idleSlots(0, 1'b1, 32);
        checkOutput("dut0 glitch frame consumed", qSize(0), 0);

        $display("[TB] 5 data bits, 8x oversample, odd parity 0x13");
        w3 = 5'h13;
        pushExpect(3, 9'h013, 1'b0, 1'b0);
        applyStimulus(3, 9'(w3), 5, 8, 1'b1, ~(^w3), 1, 1'b1, -1);
        idleSlots(3, 1'b1, 16);
        checkOutput("dut3 frame consumed", qSize(3), 0);

        $display("[TB] reset during bit 2 of the next frame");
        savedCnt = doneCnt3;
        driveBit(3, 1'b0, 8, -1);
        driveBit(3, 1'b1, 8, -1);
        driveBit(3, 1'b0, 8, -1);
        idleSlots(3, 1'b1, 4);
        rst_count = 1'b0;
        @(negedge clk);
        checkOutput("midreset dut3 d_out", 32'(dout3), 0);
        checkOutput("midreset dut3 rx_done", 32'(done3), 0);
        checkOutput("midreset dut3 frame_err", 32'(fe3), 0);
        checkOutput("midreset dut3 parity_err", 32'(pe3), 0);
        rst_count = 1'b1;
        idleSlots(3, 1'b1, 40);
        checkOutput("dut3 no rx_done from discarded frame", doneCnt3, savedCnt);

        w3 = 5'h0A;
        pushExpect(3, 9'h00A, 1'b0, 1'b0);
        applyStimulus(3, 9'(w3), 5, 8, 1'b1, ~(^w3), 1, 1'b1, -1);
        idleSlots(3, 1'b1, 16);
        checkOutput("dut3 recovery frame consumed", qSize(3), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
